// File: rtl/qpoint_adder.sv
// Registered signed fixed-point adder with one cycle of latency and a valid strobe.
// Optional saturation on narrowed outputs is enabled by defining QPOINT_ADDER_SAT_EN (otherwise the result wraps).
module qpoint_adder #(
    parameter int unsigned INP_WIDTH = 8,
    parameter int unsigned OUT_WIDTH = 9,
    parameter int unsigned FRAC_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INP_WIDTH-1:0] a,
    input  logic [INP_WIDTH-1:0] b,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] c,
    output logic                 out_valid,
    output logic                 ovf
);

    localparam int unsigned SUM_W = INP_WIDTH + 1;

    // Reject parameter sets the datapath cannot represent.
    if (INP_WIDTH < 2) begin : g_bad_inp
        $error("qpoint_adder: INP_WIDTH must be at least 2");
    end
    if (OUT_WIDTH < 2 || OUT_WIDTH > SUM_W) begin : g_bad_out
        $error("qpoint_adder: OUT_WIDTH must lie in 2 .. INP_WIDTH+1");
    end
    if (FRAC_BITS > INP_WIDTH) begin : g_bad_frac
        $error("qpoint_adder: FRAC_BITS cannot exceed INP_WIDTH");
    end

    logic [SUM_W-1:0]     sum_c;
    logic [OUT_WIDTH-1:0] c_c;
    logic                 ovf_c;

    // Full-precision sum; one guard bit means it can never overflow.
    always_comb begin
        sum_c = {a[INP_WIDTH-1], a} + {b[INP_WIDTH-1], b};
    end

    if (OUT_WIDTH == SUM_W) begin : g_full
        always_comb begin
            c_c   = sum_c;
            ovf_c = 1'b0;
        end
    end else begin : g_narrow
        localparam int unsigned TOP_W = SUM_W - OUT_WIDTH + 1;

        logic [TOP_W-1:0] top_c;

        // Sum fits iff every bit from the new sign position upward agrees.
        always_comb begin
            top_c = sum_c[SUM_W-1:OUT_WIDTH-1];
            ovf_c = !((&top_c) || !(|top_c));
            c_c   = sum_c[OUT_WIDTH-1:0];
`ifdef QPOINT_ADDER_SAT_EN
            if (ovf_c) begin
                c_c = sum_c[SUM_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
`endif
        end
    end

    // Output register; result and flag hold while no sample is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c   <= c_c;
                ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_qpoint_adder.sv
// Scoreboard bench for qpoint_adder: a default-width instance and an OUT_WIDTH=8 instance share stimulus.
module tb_qpoint_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic [8:0] c9;
    logic [7:0] c8;
    logic       ov9, ov8;
    logic       f9, f8;

    int total = 0;
    int bad   = 0;

    // Expected entries: {ovf, c} with c sign-correct in the low OUT_WIDTH bits.
    logic [9:0] q9[$];
    logic [9:0] q8[$];
    logic [9:0] last9 = '0;
    logic [9:0] last8 = '0;

    always #5 clk = ~clk;

    qpoint_adder #(.INP_WIDTH(8), .OUT_WIDTH(9), .FRAC_BITS(7)) dut9 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .c(c9), .out_valid(ov9), .ovf(f9)
    );

    qpoint_adder #(.INP_WIDTH(8), .OUT_WIDTH(8), .FRAC_BITS(7)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .c(c8), .out_valid(ov8), .ovf(f8)
    );

    // Reference: integer sum, range test, then clamp or keep (wrap is the low bits).
    function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y);
        int   s;
        int   lo;
        int   hi;
        int   r;
        logic ov;
        s  = int'($signed(x)) + int'($signed(y));
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        ov = (s < lo) || (s > hi);
        r  = s;
`ifdef QPOINT_ADDER_SAT_EN
        if (ov) r = (s > 0) ? hi : lo;
`endif
        return {ov, 9'(r)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        in_valid = 1'b1;
        q9.push_back(model(9, x, y));
        q8.push_back(model(8, x, y));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        a = 8'($urandom);
        b = 8'($urandom);
        in_valid = 1'b0;
    endtask

    // Monitor: pop on each strobe, otherwise the outputs must hold their last result.
    always @(negedge clk) begin
        if (rst) begin
            last9 <= '0;
            last8 <= '0;
        end else begin
            if (ov9) begin
                if (q9.size() == 0) begin
                    check("w9_unexpected_valid", 1, 0);
                end else begin
                    logic [9:0] e;
                    e = q9.pop_front();
                    check("w9_c", int'(c9), int'(e[8:0]));
                    check("w9_ovf", int'(f9), int'(e[9]));
                    last9 <= e;
                end
            end else begin
                check("w9_hold_c", int'(c9), int'(last9[8:0]));
                check("w9_hold_ovf", int'(f9), int'(last9[9]));
            end
            if (ov8) begin
                if (q8.size() == 0) begin
                    check("w8_unexpected_valid", 1, 0);
                end else begin
                    logic [9:0] e;
                    e = q8.pop_front();
                    check("w8_c", int'(c8), int'(e[7:0]));
                    check("w8_ovf", int'(f8), int'(e[9]));
                    last8 <= e;
                end
            end else begin
                check("w8_hold_c", int'(c8), int'(last8[7:0]));
                check("w8_hold_ovf", int'(f8), int'(last8[9]));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_c9"}, int'(c9), 0);
        check({tag, "_ov9"}, int'(ov9), 0);
        check({tag, "_f9"}, int'(f9), 0);
        check({tag, "_c8"}, int'(c8), 0);
        check({tag, "_ov8"}, int'(ov8), 0);
        check({tag, "_f8"}, int'(f8), 0);
    endtask

    initial begin
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        #3;
        check_reset_state("por");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Directed vectors, each a single strobe followed by an idle cycle.
        send(8'h3A, 8'h41); idle();
        send(8'h3A, 8'hE8); idle();
        send(8'h80, 8'h80); idle();
        send(8'h7F, 8'h7F); idle();
        send(8'h80, 8'hFF); idle();
        send(8'h00, 8'h00); idle();
        send(8'hC0, 8'hC0); idle();
        send(8'h40, 8'h40); idle(); idle();

        // Back-to-back stream of 125 random samples.
        for (int i = 0; i < 125; i++) send(8'($urandom), 8'($urandom));
        idle(); idle();

        // Random traffic with gaps.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) != 0) send(8'($urandom), 8'($urandom));
            else idle();
        end
        idle(); idle();

        // Asynchronous reset between edges with a sample in flight.
        send(8'h7F, 8'h7F);
        #2;
        rst = 1'b1;
        q9.delete();
        q8.delete();
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        #1;
        rst = 1'b0;
        a = 8'h9C;
        b = 8'hB0;
        q9.push_back(model(9, 8'h9C, 8'hB0));
        q8.push_back(model(8, 8'h9C, 8'hB0));
        idle(); idle(); idle();

        check("q9_drained", q9.size(), 0);
        check("q8_drained", q8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
